// File: rtl/phs_flow_classifier.sv
// PHS flow classifier: buffers parser PHS tuples in a small FIFO, then scans a
// masked-match rule table one entry per cycle; the lowest-index match wins.
module phs_flow_classifier #(
    parameter  int PHS_W      = 120,
    parameter  int NUM_RULES  = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int QFI_W      = 6,
    parameter  int CNT_W      = 16,
    localparam int IDX_W      = $clog2(NUM_RULES)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [PHS_W-1:0] phs_i,
    input  logic             phs_valid_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic             cfg_valid_i,
    input  logic [PHS_W-1:0] cfg_key_i,
    input  logic [PHS_W-1:0] cfg_mask_i,
    input  logic [QFI_W-1:0] cfg_qfi_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_hit_o,
    output logic [IDX_W-1:0] res_idx_o,
    output logic [QFI_W-1:0] res_qfi_o,
    output logic [PHS_W-1:0] res_phs_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESULT} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PHS_W-1:0]       tuple_q, tuple_d;
    logic                   res_hit_q, res_hit_d;
    logic [IDX_W-1:0]       res_idx_q, res_idx_d;
    logic [QFI_W-1:0]       res_qfi_q, res_qfi_d;

    logic [NUM_RULES-1:0]   rvalid_q;
    logic [PHS_W-1:0]       key_q  [NUM_RULES];
    logic [PHS_W-1:0]       mask_q [NUM_RULES];
    logic [QFI_W-1:0]       qfi_q  [NUM_RULES];

    logic [PHS_W-1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]         count_q, count_d;
    logic                   full, push, pop, match, handshake;

    logic [CNT_W-1:0]       drop_cnt_q, hit_cnt_q, miss_cnt_q;

    // Rule table: only the valid bits need a reset value.
    always_ff @(posedge CLK) begin
        if (reset) rvalid_q <= '0;
        else if (cfg_we_i) rvalid_q[cfg_idx_i] <= cfg_valid_i;
    end

    always_ff @(posedge CLK) begin
        if (cfg_we_i) begin
            key_q[cfg_idx_i]  <= cfg_key_i;
            mask_q[cfg_idx_i] <= cfg_mask_i;
            qfi_q[cfg_idx_i]  <= cfg_qfi_i;
        end
    end

    // Full is judged on pre-pop occupancy, so a push into a full FIFO drops.
    assign full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign push = phs_valid_i && !full;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= phs_i;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign match = rvalid_q[idx_q] &&
                   (((tuple_q ^ key_q[idx_q]) & mask_q[idx_q]) == '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tuple_d   = tuple_q;
        res_hit_d = res_hit_q;
        res_idx_d = res_idx_q;
        res_qfi_d = res_qfi_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    tuple_d = fifo_mem_q[rd_ptr_q];
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (match) begin
                    res_hit_d = 1'b1;
                    res_idx_d = idx_q;
                    res_qfi_d = qfi_q[idx_q];
                    state_d   = S_RESULT;
                end else if (idx_q == IDX_W'(NUM_RULES-1)) begin
                    res_hit_d = 1'b0;
                    res_idx_d = '0;
                    res_qfi_d = '0;
                    state_d   = S_RESULT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_RESULT: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tuple_q   <= '0;
            res_hit_q <= 1'b0;
            res_idx_q <= '0;
            res_qfi_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tuple_q   <= tuple_d;
            res_hit_q <= res_hit_d;
            res_idx_q <= res_idx_d;
            res_qfi_q <= res_qfi_d;
        end
    end

    assign handshake = (state_q == S_RESULT) && res_ready_i;

    // Statistics saturate at all-ones.
    always_ff @(posedge CLK) begin
        if (reset) begin
            drop_cnt_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (phs_valid_i && full && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            if (handshake && res_hit_q && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (handshake && !res_hit_q && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign res_valid_o = (state_q == S_RESULT);
    assign res_hit_o   = res_hit_q;
    assign res_idx_o   = res_idx_q;
    assign res_qfi_o   = res_qfi_q;
    assign res_phs_o   = tuple_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_phs_flow_classifier.sv
// Directed bench for phs_flow_classifier: hit/priority/miss latency,
// backpressure with FIFO overflow, same-cycle rule write, reset mid-scan.
module tb_phs_flow_classifier;

    localparam int PHS_W      = 120;
    localparam int NUM_RULES  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int QFI_W      = 6;
    localparam int CNT_W      = 16;
    localparam int IDX_W      = $clog2(NUM_RULES);

    logic             clk = 1'b0;
    logic             reset;
    logic [PHS_W-1:0] phs;
    logic             phs_valid;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic             cfg_valid;
    logic [PHS_W-1:0] cfg_key;
    logic [PHS_W-1:0] cfg_mask;
    logic [QFI_W-1:0] cfg_qfi;
    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;
    logic [QFI_W-1:0] res_qfi;
    logic [PHS_W-1:0] res_phs;
    logic [CNT_W-1:0] drop_cnt, hit_cnt, miss_cnt;

    int n_vec     = 0;
    int n_miscmp  = 0;

    phs_flow_classifier #(
        .PHS_W      (PHS_W),
        .NUM_RULES  (NUM_RULES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .QFI_W      (QFI_W),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK         (clk),
        .reset       (reset),
        .phs_i       (phs),
        .phs_valid_i (phs_valid),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_valid_i (cfg_valid),
        .cfg_key_i   (cfg_key),
        .cfg_mask_i  (cfg_mask),
        .cfg_qfi_i   (cfg_qfi),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_hit_o   (res_hit),
        .res_idx_o   (res_idx),
        .res_qfi_o   (res_qfi),
        .res_phs_o   (res_phs),
        .drop_cnt_o  (drop_cnt),
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PHS_W-1:0] mk_phs(input logic [7:0] tos, input logic [15:0] sport,
                                                input logic [15:0] dport, input logic [7:0] proto,
                                                input logic [31:0] sip, input logic [31:0] dip);
        return {8'h03, tos, sport, dport, proto, sip, dip};
    endfunction

    task automatic wr_rule(input int idx, input logic v, input logic [PHS_W-1:0] key,
                           input logic [PHS_W-1:0] mask, input logic [QFI_W-1:0] qfi);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_valid = v;
        cfg_key   = key;
        cfg_mask  = mask;
        cfg_qfi   = qfi;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Returns ticks spent waiting; a large negative value marks a timeout.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        if (!res_valid) n = -1000;
    endtask

    // Strobe one tuple and return the cycle offset at which res_valid rises.
    task automatic push_and_time(input logic [PHS_W-1:0] t, output int lat);
        int m;
        phs       = t;
        phs_valid = 1'b1;
        tick();
        phs_valid = 1'b0;
        wait_valid(40, m);
        lat = 1 + m;
    endtask

    logic [PHS_W-1:0] t1, t2, key_dst, mask_dst, mask_proto, mask_all;
    logic [PHS_W-1:0] tq [6];
    int lat, m, seen;

    initial begin
        reset = 1'b1; phs = '0; phs_valid = 1'b0; res_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
        cfg_key = '0; cfg_mask = '0; cfg_qfi = '0;

        t1         = mk_phs(8'h10, 16'd1234, 16'd80, 8'd6, 32'hC0A80001, 32'h0A000001);
        t2         = mk_phs(8'h20, 16'd5555, 16'd443, 8'd17, 32'hAC100005, 32'h08080808);
        key_dst    = mk_phs(8'h00, 16'd0, 16'd0, 8'd0, 32'h0, 32'h0A000001);
        mask_dst   = {88'h0, 32'hFFFF_FFFF};
        mask_proto = mk_phs(8'h00, 16'd0, 16'd0, 8'hFF, 32'h0, 32'h0) & {8'h00, {112{1'b1}}};
        mask_all   = '1;

        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", res_valid, 0);
        chk("rst_hit",   res_hit,   0);
        chk("rst_idx",   res_idx,   0);
        chk("rst_qfi",   res_qfi,   0);
        chk("rst_phs",   res_phs,   0);
        chk("rst_drop",  drop_cnt,  0);
        chk("rst_hitc",  hit_cnt,   0);
        chk("rst_missc", miss_cnt,  0);

        // Single dstIP rule at index 2: hit at t+5.
        wr_rule(2, 1'b1, key_dst, mask_dst, 6'd5);
        push_and_time(t1, lat);
        chk("hit2_lat", lat, 5);
        chk("hit2_hit", res_hit, 1);
        chk("hit2_idx", res_idx, 2);
        chk("hit2_qfi", res_qfi, 5);
        chk("hit2_phs", res_phs, t1);
        tick();
        chk("hit2_vld_drop", res_valid, 0);
        chk("hit2_hitc", hit_cnt, 1);

        // Rules 1 and 3 also match; index 1 wins at t+4.
        wr_rule(1, 1'b1, t1, mask_proto, 6'd7);
        wr_rule(3, 1'b1, t1, mask_all, 6'd9);
        push_and_time(t1, lat);
        chk("prio_lat", lat, 4);
        chk("prio_idx", res_idx, 1);
        chk("prio_qfi", res_qfi, 7);
        tick();
        chk("prio_hitc", hit_cnt, 2);

        // No valid rules: miss at t+2+NUM_RULES.
        wr_rule(1, 1'b0, '0, '0, 6'd0);
        wr_rule(2, 1'b0, '0, '0, 6'd0);
        wr_rule(3, 1'b0, '0, '0, 6'd0);
        push_and_time(t1, lat);
        chk("miss_lat", lat, 2 + NUM_RULES);
        chk("miss_hit", res_hit, 0);
        chk("miss_idx", res_idx, 0);
        chk("miss_qfi", res_qfi, 0);
        tick();
        chk("miss_missc", miss_cnt, 1);

        // Backpressure: 6 back-to-back tuples, one in scan, four queued, one dropped.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tq[i]     = mk_phs(8'h40, 16'd100, 16'd200, 8'd6, 32'h01020304, 32'(i + 16));
            phs       = tq[i];
            phs_valid = 1'b1;
            tick();
        end
        phs_valid = 1'b0;
        chk("bp_drop", drop_cnt, 1);
        wait_valid(40, m);
        chk("bp_first_vld", res_valid, 1);
        chk("bp_first_phs", res_phs, tq[0]);
        tick(); tick(); tick();
        chk("bp_hold_vld", res_valid, 1);
        chk("bp_hold_phs", res_phs, tq[0]);
        chk("bp_hold_hit", res_hit, 0);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(40, m);
            chk($sformatf("bp_order%0d", k), res_phs, tq[k]);
            tick();
        end
        chk("bp_missc", miss_cnt, 6);
        chk("bp_drop_end", drop_cnt, 1);

        // Rule 0 written in the very cycle entry 0 is compared: old contents used.
        phs = t1; phs_valid = 1'b1;
        tick();
        phs_valid = 1'b0;
        tick();
        wr_rule(0, 1'b1, t1, mask_all, 6'd3);
        wait_valid(40, m);
        chk("wr_race_lat", 3 + m, 2 + NUM_RULES);
        chk("wr_race_hit", res_hit, 0);
        tick();
        push_and_time(t1, lat);
        chk("wr_done_lat", lat, 3);
        chk("wr_done_hit", res_hit, 1);
        chk("wr_done_idx", res_idx, 0);
        chk("wr_done_qfi", res_qfi, 3);
        tick();
        chk("wr_hitc",  hit_cnt,  3);
        chk("wr_missc", miss_cnt, 7);

        // Reset during a scan with two tuples queued.
        for (int i = 0; i < 3; i++) begin
            phs = t2; phs_valid = 1'b1;
            tick();
        end
        phs_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_valid", res_valid, 0);
        chk("rs_drop",  drop_cnt,  0);
        chk("rs_hitc",  hit_cnt,   0);
        chk("rs_missc", miss_cnt,  0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("rs_fifo_empty", seen, 0);
        push_and_time(t1, lat);
        chk("rs_rules_lat", lat, 2 + NUM_RULES);
        chk("rs_rules_hit", res_hit, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
